// File: rtl/tdnn_buf_pkg.sv
// Shared definitions for the TDNN ping-pong activation buffer.
package tdnn_buf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      SWAP  = 2'd2
   } swap_state_e;

endpackage

// File: rtl/tdnn_pp_ram.sv
// Single bank: one write port, one registered read port, read-before-write.
module tdnn_pp_ram #(
   parameter int DW = 16,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          re,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rd <= mem[ra];
   end

endmodule

// File: rtl/tdnn_pp_buf.sv
// Ping-pong buffer: host fills one bank while the engine reads/accumulates
// into the other; swap_req hands the banks over once engine traffic drains.
module tdnn_pp_buf
   import tdnn_buf_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          host_wv,
   input  logic [AW-1:0] host_wa,
   input  logic [DW-1:0] host_wd,
   input  logic          host_rv,
   input  logic [AW-1:0] host_ra,
   output logic [DW-1:0] host_rd,
   output logic          host_rdv,
   input  logic          eng_rv,
   input  logic [AW-1:0] eng_ra,
   output logic [DW-1:0] eng_rd,
   output logic          eng_rdv,
   input  logic          eng_wv,
   input  logic          eng_acc,
   input  logic [AW-1:0] eng_wa,
   input  logic [DW-1:0] eng_wd,
   input  logic          swap_req,
   output logic          swap_ack,
   output logic          eng_bank,
   output logic          busy
);

   swap_state_e state;

   logic          acc0, e_re0, h_re0, fwd0, drain_ok;
   logic [AW-1:0] e_ra0;

   logic          s1_valid, s1_acc, fwd_q, e_bank_q, h_bank_q;
   logic [AW-1:0] s1_addr;
   logic [DW-1:0] s1_wd, fwd_data_q, e_old, s1_wdata;
   logic [DW-1:0] host_rd_hold, eng_rd_hold;

   logic          ram_we [2];
   logic          ram_re [2];
   logic [AW-1:0] ram_wa [2];
   logic [AW-1:0] ram_ra [2];
   logic [DW-1:0] ram_wd [2];
   logic [DW-1:0] ram_rd [2];

   // Stage 0: an accumulate borrows the engine read port for its old value.
   assign acc0  = eng_wv && eng_acc;
   assign e_re0 = eng_rv || acc0;
   assign e_ra0 = acc0 ? eng_wa : eng_ra;
   assign h_re0 = host_rv && !host_wv;

   // All engine writes retire from stage 1, so the bank needs only one write
   // port; a stage-0 read of the address being retired takes the forwarded value.
   assign fwd0     = s1_valid && e_re0 && (s1_addr == e_ra0) && (e_bank_q == eng_bank);
   assign e_old    = fwd_q ? fwd_data_q : ram_rd[e_bank_q];
   assign s1_wdata = s1_acc ? e_old + s1_wd : s1_wd;

   assign eng_rd  = eng_rdv  ? e_old            : eng_rd_hold;
   assign host_rd = host_rdv ? ram_rd[h_bank_q] : host_rd_hold;

   assign drain_ok = !eng_rv && !eng_wv && !(s1_valid && s1_acc);
   assign swap_ack = (state == SWAP);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         s1_acc       <= 1'b0;
         fwd_q        <= 1'b0;
         eng_rdv      <= 1'b0;
         host_rdv     <= 1'b0;
         e_bank_q     <= 1'b0;
         h_bank_q     <= 1'b0;
         host_rd_hold <= '0;
         eng_rd_hold  <= '0;
      end else begin
         s1_valid     <= eng_wv;
         s1_acc       <= acc0;
         fwd_q        <= fwd0;
         eng_rdv      <= eng_rv && !acc0;
         host_rdv     <= h_re0;
         e_bank_q     <= eng_bank;
         h_bank_q     <= ~eng_bank;
         host_rd_hold <= host_rd;
         eng_rd_hold  <= eng_rd;
      end
   end

   always_ff @(posedge clk) begin
      s1_addr    <= eng_wa;
      s1_wd      <= eng_wd;
      fwd_data_q <= s1_wdata;
   end

   // The bank flips on leaving SWAP, so host traffic in the SWAP cycle still
   // sees the pre-swap bank.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         eng_bank <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (swap_req) state <= DRAIN;
            DRAIN:   if (drain_ok) state <= SWAP;
            SWAP: begin
               state    <= IDLE;
               eng_bank <= ~eng_bank;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage-1 writes follow their issue bank and take priority over the host.
   always_comb begin
      for (int unsigned b = 0; b < 2; b++) begin
         ram_we[b] = (s1_valid && e_bank_q == b[0]) || (host_wv && eng_bank != b[0]);
         ram_wa[b] = (s1_valid && e_bank_q == b[0]) ? s1_addr  : host_wa;
         ram_wd[b] = (s1_valid && e_bank_q == b[0]) ? s1_wdata : host_wd;
         ram_re[b] = (eng_bank == b[0]) ? e_re0 : h_re0;
         ram_ra[b] = (eng_bank == b[0]) ? e_ra0 : host_ra;
      end
   end

   tdnn_pp_ram #(.DW(DW), .AW(AW)) u_bank0 (
      .clk (clk),
      .we  (ram_we[0]),
      .wa  (ram_wa[0]),
      .wd  (ram_wd[0]),
      .re  (ram_re[0]),
      .ra  (ram_ra[0]),
      .rd  (ram_rd[0])
   );

   tdnn_pp_ram #(.DW(DW), .AW(AW)) u_bank1 (
      .clk (clk),
      .we  (ram_we[1]),
      .wa  (ram_wa[1]),
      .wd  (ram_wd[1]),
      .re  (ram_re[1]),
      .ra  (ram_ra[1]),
      .rd  (ram_rd[1])
   );

endmodule

// File: tb/tb_tdnn_pp_buf.sv
// Scoreboard bench for tdnn_pp_buf against a transaction-level memory/swap model.
module tb_tdnn_pp_buf;

   localparam int DW = 16;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          host_wv = 1'b0, host_rv = 1'b0;
   logic [AW-1:0] host_wa = '0, host_ra = '0;
   logic [DW-1:0] host_wd = '0;
   logic [DW-1:0] host_rd;
   logic          host_rdv;
   logic          eng_rv = 1'b0, eng_wv = 1'b0, eng_acc = 1'b0;
   logic [AW-1:0] eng_ra = '0, eng_wa = '0;
   logic [DW-1:0] eng_wd = '0;
   logic [DW-1:0] eng_rd;
   logic          eng_rdv;
   logic          swap_req = 1'b0;
   logic          swap_ack, eng_bank, busy;

   always #5 clk = ~clk;

   tdnn_pp_buf #(.DW(DW), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .host_wv  (host_wv),
      .host_wa  (host_wa),
      .host_wd  (host_wd),
      .host_rv  (host_rv),
      .host_ra  (host_ra),
      .host_rd  (host_rd),
      .host_rdv (host_rdv),
      .eng_rv   (eng_rv),
      .eng_ra   (eng_ra),
      .eng_rd   (eng_rd),
      .eng_rdv  (eng_rdv),
      .eng_wv   (eng_wv),
      .eng_acc  (eng_acc),
      .eng_wa   (eng_wa),
      .eng_wd   (eng_wd),
      .swap_req (swap_req),
      .swap_ack (swap_ack),
      .eng_bank (eng_bank),
      .busy     (busy)
   );

   typedef struct {
      bit          rn, hwv, hrv, erv, ewv, eacc, sreq;
      bit [AW-1:0] hwa, hra, era, ewa;
      bit [DW-1:0] hwd, ewd;
   } stim_t;

   typedef struct {
      bit [DW-1:0] data;
      int unsigned due;
   } rd_exp_t;

   typedef struct {
      bit          ack, busy, bank;
      int unsigned due;
   } ctl_exp_t;

   rd_exp_t  hq[$];
   rd_exp_t  eq[$];
   ctl_exp_t cq[$];

   // Reference model: plain per-bank arrays updated in issue order.
   bit [DW-1:0] mem [2][4096];
   bit          m_bank = 0, m_pend = 0, m_ack = 0, m_prev_acc = 0;

   int unsigned cyc = 0;
   int unsigned n_cmp = 0, n_err = 0;
   bit          rst_q = 0;
   bit [DW-1:0] h_last = '0, e_last = '0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      s.rn = 1'b1;
      return s;
   endfunction

   task automatic step(input stim_t s);
      ctl_exp_t c;
      rd_exp_t  r;
      bit       hb, eb;
      @(posedge clk);
      #1;
      if (!s.rn) begin
         s = idle();
         s.rn = 1'b0;
      end
      rst_n = s.rn;    host_wv = s.hwv; host_wa = s.hwa; host_wd = s.hwd;
      host_rv = s.hrv; host_ra = s.hra; eng_rv = s.erv;  eng_ra = s.era;
      eng_wv = s.ewv;  eng_acc = s.eacc; eng_wa = s.ewa; eng_wd = s.ewd;
      swap_req = s.sreq;

      c.ack = m_ack; c.busy = m_pend || m_ack; c.bank = m_bank; c.due = cyc;
      cq.push_back(c);

      if (!s.rn) begin
         m_pend = 0; m_ack = 0; m_bank = 0; m_prev_acc = 0;
         return;
      end

      hb = !m_bank;
      eb = m_bank;
      if (s.hwv) mem[hb][s.hwa] = s.hwd;
      else if (s.hrv) begin
         r.data = mem[hb][s.hra]; r.due = cyc + 1; hq.push_back(r);
      end
      if (s.erv && !(s.ewv && s.eacc)) begin
         r.data = mem[eb][s.era]; r.due = cyc + 1; eq.push_back(r);
      end
      if (s.ewv) mem[eb][s.ewa] = s.eacc ? mem[eb][s.ewa] + s.ewd : s.ewd;

      // Swap handshake: request, wait for a quiet engine cycle, acknowledge, flip.
      if (m_ack) begin
         m_ack = 0; m_bank = !m_bank;
      end else if (m_pend) begin
         if (!s.erv && !s.ewv && !m_prev_acc) begin
            m_pend = 0; m_ack = 1;
         end
      end else if (s.sreq) m_pend = 1;
      m_prev_acc = s.ewv && s.eacc;
   endtask

   task automatic do_swap();
      stim_t s;
      s = idle();
      s.sreq = 1'b1;
      step(s);
      for (int i = 0; i < 8 && (m_pend || m_ack); i++) step(idle());
   endtask

   // Monitor: reads must appear exactly on their due cycle; outputs hold otherwise.
   always @(negedge clk) begin
      if (cyc >= 1) begin
         if (!rst_q) begin
            h_last = '0;
            e_last = '0;
         end
         n_cmp++;
         if (hq.size() > 0 && hq[0].due == cyc) begin
            if (host_rdv !== 1'b1 || host_rd !== hq[0].data) begin
               n_err++;
               $display("FAIL host_read cyc=%0d: got rdv=%b rd=%h, want rdv=1 rd=%h",
                        cyc, host_rdv, host_rd, hq[0].data);
            end
            h_last = hq[0].data;
            void'(hq.pop_front());
         end else if (host_rdv !== 1'b0 || host_rd !== h_last) begin
            n_err++;
            $display("FAIL host_hold cyc=%0d: got rdv=%b rd=%h, want rdv=0 rd=%h",
                     cyc, host_rdv, host_rd, h_last);
         end
         n_cmp++;
         if (eq.size() > 0 && eq[0].due == cyc) begin
            if (eng_rdv !== 1'b1 || eng_rd !== eq[0].data) begin
               n_err++;
               $display("FAIL eng_read cyc=%0d: got rdv=%b rd=%h, want rdv=1 rd=%h",
                        cyc, eng_rdv, eng_rd, eq[0].data);
            end
            e_last = eq[0].data;
            void'(eq.pop_front());
         end else if (eng_rdv !== 1'b0 || eng_rd !== e_last) begin
            n_err++;
            $display("FAIL eng_hold cyc=%0d: got rdv=%b rd=%h, want rdv=0 rd=%h",
                     cyc, eng_rdv, eng_rd, e_last);
         end
         if (cq.size() > 0 && cq[0].due == cyc) begin
            n_cmp++;
            if (swap_ack !== cq[0].ack || busy !== cq[0].busy || eng_bank !== cq[0].bank) begin
               n_err++;
               $display("FAIL swap_ctl cyc=%0d: got ack=%b busy=%b bank=%b, want ack=%b busy=%b bank=%b",
                        cyc, swap_ack, busy, eng_bank, cq[0].ack, cq[0].busy, cq[0].bank);
            end
            void'(cq.pop_front());
         end
      end
   end

   initial begin
      stim_t s;

      s = idle(); s.rn = 1'b0;
      step(s);
      step(s);
      step(idle());

      // Fill addresses 0..15 of both banks so every later read is defined.
      for (int unsigned a = 0; a < 16; a++) begin
         s = idle(); s.hwv = 1; s.hwa = AW'(a); s.hwd = DW'($urandom); step(s);
      end
      do_swap();
      for (int unsigned a = 0; a < 16; a++) begin
         s = idle(); s.hwv = 1; s.hwa = AW'(a); s.hwd = DW'($urandom); step(s);
      end

      // Host write then swap, engine reads it back.
      s = idle(); s.hwv = 1; s.hwa = 5; s.hwd = 16'h1234; step(s);
      do_swap();
      s = idle(); s.erv = 1; s.era = 5; step(s);
      step(idle());

      // Back-to-back accumulates 3,4,5 onto 10.
      s = idle(); s.hwv = 1; s.hwa = 7; s.hwd = 16'd10; step(s);
      do_swap();
      for (int unsigned k = 3; k <= 5; k++) begin
         s = idle(); s.ewv = 1; s.eacc = 1; s.ewa = 7; s.ewd = DW'(k); step(s);
      end
      do_swap();
      s = idle(); s.hrv = 1; s.hra = 7; step(s);
      step(idle());

      // Wrap: 0xFFFF + 2, both forwarded and after a gap.
      s = idle(); s.ewv = 1; s.ewa = 0; s.ewd = 16'hFFFF; step(s);
      s = idle(); s.ewv = 1; s.eacc = 1; s.ewa = 0; s.ewd = 16'd2; step(s);
      s = idle(); s.erv = 1; s.era = 0; step(s);
      s = idle(); s.ewv = 1; s.ewa = 1; s.ewd = 16'hFFFF; step(s);
      step(idle());
      s = idle(); s.ewv = 1; s.eacc = 1; s.ewa = 1; s.ewd = 16'd2; step(s);
      step(idle());
      s = idle(); s.erv = 1; s.era = 1; step(s);

      // Same-cycle read and overwrite returns old data; read beside accumulate is dropped.
      s = idle(); s.erv = 1; s.era = 4; s.ewv = 1; s.ewa = 4; s.ewd = 16'hAAAA; step(s);
      s = idle(); s.erv = 1; s.era = 4; step(s);
      s = idle(); s.erv = 1; s.era = 4; s.ewv = 1; s.eacc = 1; s.ewa = 4; s.ewd = 16'd1; step(s);
      s = idle(); s.erv = 1; s.era = 4; step(s);

      // Host write and read collide: read dropped, next read sees new data.
      s = idle(); s.hwv = 1; s.hwa = 3; s.hwd = 16'hBEEF; s.hrv = 1; s.hra = 3; step(s);
      s = idle(); s.hrv = 1; s.hra = 3; step(s);
      step(idle());

      // Swap requested with accumulates in flight; drain holds until stage 1 empties.
      s = idle(); s.ewv = 1; s.eacc = 1; s.ewa = 9; s.ewd = 16'd1; s.sreq = 1; step(s);
      s.sreq = 0; s.ewd = 16'd6; step(s);
      for (int i = 0; i < 6; i++) step(idle());
      s = idle(); s.hrv = 1; s.hra = 9; step(s);
      step(idle());

      // Reset in DRAIN while engine bank is 1: handshake abandoned.
      s = idle(); s.sreq = 1; step(s);
      s = idle(); s.erv = 1; s.era = 2; step(s);
      step(s);
      s = idle(); s.rn = 1'b0; step(s);
      for (int i = 0; i < 4; i++) step(idle());

      // Random mixed traffic over a small address window.
      for (int i = 0; i < 400; i++) begin
         s = idle();
         s.hwv = ($urandom_range(0, 3) == 0);
         s.hwa = AW'($urandom_range(0, 15));
         s.hwd = DW'($urandom);
         s.hrv = ($urandom_range(0, 2) == 0);
         s.hra = AW'($urandom_range(0, 15));
         s.erv = ($urandom_range(0, 2) == 0);
         s.era = AW'($urandom_range(0, 15));
         s.ewv = ($urandom_range(0, 2) == 0) && !m_ack;
         s.eacc = ($urandom_range(0, 1) == 1);
         s.ewa = AW'($urandom_range(0, 15));
         s.ewd = DW'($urandom);
         s.sreq = ($urandom_range(0, 15) == 0);
         step(s);
      end
      for (int i = 0; i < 4; i++) step(idle());

      @(negedge clk);
      #1;
      n_cmp++;
      if (hq.size() != 0 || eq.size() != 0 || cq.size() != 0) begin
         n_err++;
         $display("FAIL drain_queues: got host=%0d eng=%0d ctl=%0d pending, want 0/0/0",
                  hq.size(), eq.size(), cq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
